// File: rtl/seq_shifter.sv
// Sequential shifter: applies one 1-bit shift/rotate step per clock to a captured operand.
// Latency: done is high in the cycle after edge k+amt, where edge k accepts start (amt=0 gives done one cycle after accept).
// Backpressure: busy is high from accept through the done cycle; start/x/amt/mode are ignored while busy, with no queuing.
//
// Ports:
//   clk   - sole clock, rising edge
//   rst_n - synchronous active-low reset
//   start - request, sampled only in IDLE
//   mode  - 000 hold, 001 SLL, 010 SRL, 011 SRA, 100 ROL, 101 ROR, 11x hold
//   amt   - number of 1-bit steps (0..N-1)
//   x     - operand loaded at accept
//   f     - working/result register
//   cout  - last bit shifted or rotated out
//   ove   - sticky signed overflow, SLL only
//   busy  - state != IDLE
//   done  - one-cycle completion pulse
module seq_shifter #(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [2:0]    mode,
    input  logic [AW-1:0] amt,
    input  logic [N-1:0]  x,
    output logic [N-1:0]  f,
    output logic          cout,
    output logic          ove,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] MODE_SLL = 3'b001;
    localparam logic [2:0] MODE_SRL = 3'b010;
    localparam logic [2:0] MODE_SRA = 3'b011;
    localparam logic [2:0] MODE_ROL = 3'b100;
    localparam logic [2:0] MODE_ROR = 3'b101;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   cnt;
    logic [2:0]      mode_q;

    logic [N-1:0]    f_step;
    logic            cout_step;
    logic            ove_step;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. cnt holds the steps still to perform, so the
    // step taken while cnt == 1 is the last one.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (amt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (cnt == AW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One 1-bit step of the latched operation. Hold and reserved modes
    // leave f and cout untouched while the step count still runs down.
    always_comb begin
        f_step    = f;
        cout_step = cout;
        ove_step  = 1'b0;
        case (mode_q)
            MODE_SLL: begin
                f_step    = {f[N-2:0], 1'b0};
                cout_step = f[N-1];
                // Sign bit changes on this step exactly when the top two bits differ.
                ove_step  = f[N-1] ^ f[N-2];
            end
            MODE_SRL: begin
                f_step    = {1'b0, f[N-1:1]};
                cout_step = f[0];
            end
            MODE_SRA: begin
                f_step    = {f[N-1], f[N-1:1]};
                cout_step = f[0];
            end
            MODE_ROL: begin
                f_step    = {f[N-2:0], f[N-1]};
                cout_step = f[N-1];
            end
            MODE_ROR: begin
                f_step    = {f[0], f[N-1:1]};
                cout_step = f[0];
            end
            default: begin
                f_step    = f;
                cout_step = cout;
            end
        endcase
    end

    // Datapath: loads on accept, steps in SHIFT, holds everywhere else.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f      <= '0;
            cnt    <= '0;
            cout   <= 1'b0;
            ove    <= 1'b0;
            mode_q <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        f      <= x;
                        cnt    <= amt;
                        mode_q <= mode;
                        cout   <= 1'b0;
                        ove    <= 1'b0;
                    end
                end
                SHIFT: begin
                    f    <= f_step;
                    cout <= cout_step;
                    ove  <= ove | ove_step;
                    cnt  <= cnt - AW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Testbench for seq_shifter (N=8): directed literal cases plus randomized traffic
// checked every cycle against an arithmetic model keyed on the accept edge.
module tb_seq_shifter;

    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [2:0]    mode;
    logic [AW-1:0] amt;
    logic [N-1:0]  x;
    logic [N-1:0]  f;
    logic          cout;
    logic          ove;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    seq_shifter #(.N(N), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
        .amt   (amt),
        .x     (x),
        .f     (f),
        .cout  (cout),
        .ove   (ove),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Result of applying operation md to v for j single-bit steps:
    // returns {ove, cout, f}.
    function automatic logic [9:0] op(input logic [7:0] v, input logic [2:0] md, input int j);
        logic [15:0] w;
        logic [7:0]  r;
        logic        c;
        logic        o;
        int          top;
        r = v;
        c = 1'b0;
        o = 1'b0;
        if (j > 0) begin
            case (md)
                3'd1: begin
                    r   = v << j;
                    c   = v[8-j];
                    // Overflow at some step iff the top j+1 bits of v are not all equal.
                    top = int'(v) >> (7 - j);
                    o   = !(top == 0 || top == ((1 << (j + 1)) - 1));
                end
                3'd2: begin
                    r = v >> j;
                    c = v[j-1];
                end
                3'd3: begin
                    r = $signed(v) >>> j;
                    c = v[j-1];
                end
                3'd4: begin
                    w = {v, v} << j;
                    r = w[15:8];
                    c = v[8-j];
                end
                3'd5: begin
                    w = {v, v} >> j;
                    r = w[7:0];
                    c = v[j-1];
                end
                default: begin
                end
            endcase
        end
        return {o, c, r};
    endfunction

    // Reference model: remembers the accept edge k and the captured request;
    // outputs after edge e follow from how many steps (e-k, capped at amt) have run.
    bit         mvalid = 1'b0;
    bit         have   = 1'b0;
    int         e_cnt  = 0;
    int         k_edge = 0;
    logic [7:0] mx;
    logic [2:0] mm;
    int         ma = 0;
    logic [7:0] ef;
    logic       ec, eo, eb, ed;

    always @(posedge clk) begin
        int j;
        e_cnt++;
        if (!rst_n) begin
            have   = 1'b0;
            mvalid = 1'b1;
        end else if (!(have && e_cnt <= k_edge + ma + 1) && start) begin
            have   = 1'b1;
            k_edge = e_cnt;
            mx     = x;
            mm     = mode;
            ma     = int'(amt);
        end
        if (have) begin
            j = e_cnt - k_edge;
            eb = (j <= ma);
            ed = (j == ma);
            if (j > ma) j = ma;
            {eo, ec, ef} = op(mx, mm, j);
        end else begin
            ef = 8'h00;
            ec = 1'b0;
            eo = 1'b0;
            eb = 1'b0;
            ed = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("cyc_f",    32'(f),    32'(ef));
            chk("cyc_cout", 32'(cout), 32'(ec));
            chk("cyc_ove",  32'(ove),  32'(eo));
            chk("cyc_busy", 32'(busy), 32'(eb));
            chk("cyc_done", 32'(done), 32'(ed));
        end
    end

    // Issue one request and wait (bounded) for done; optionally pulse start
    // with a different operand while busy and during the done cycle.
    task automatic do_op(input logic [2:0] md, input logic [2:0] a, input logic [7:0] xv,
                         input bit poke, output int bcyc, output bit got);
        @(negedge clk);
        start = 1'b1; mode = md; amt = a; x = xv;
        @(negedge clk);
        start = 1'b0;
        bcyc = 0;
        got  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy) bcyc++;
            if (done) begin
                got = 1'b1;
                break;
            end
            start = poke;
            if (poke) begin
                x = 8'h3C; mode = 3'd1; amt = 3'd2;
            end
            @(negedge clk);
        end
        start = poke;
        if (poke) x = 8'hC3;
        @(negedge clk);
        start = 1'b0;
    endtask

    logic [2:0] t_mode [8] = '{3'd1, 3'd1, 3'd1, 3'd3, 3'd2, 3'd4, 3'd5, 3'd5};
    logic [2:0] t_amt  [8] = '{3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd1, 3'd7, 3'd0};
    logic [7:0] t_x    [8] = '{8'h01, 8'h60, 8'h80, 8'h90, 8'h90, 8'h81, 8'h01, 8'h5A};
    bit         t_poke [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] t_f    [8] = '{8'h02, 8'hC0, 8'h00, 8'hF2, 8'h12, 8'h03, 8'h02, 8'h5A};
    logic       t_c    [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       t_o    [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int         t_b    [8] = '{2, 2, 2, 4, 4, 2, 8, 1};

    initial begin
        int  bc;
        bit  got;
        bit  seen_done;

        rst_n = 1'b0; start = 1'b0; mode = 3'd0; amt = '0; x = '0;
        repeat (2) @(negedge clk);
        chk("rst_f",    32'(f),    32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        rst_n = 1'b1;

        // Model pins on hand-computed values.
        chk("model_sra", 32'(op(8'h90, 3'd3, 3)), 32'h0F2);
        chk("model_sll", 32'(op(8'h80, 3'd1, 1)), 32'h300);

        // Directed cases; the first is accepted on the first edge after reset release.
        for (int t = 0; t < 8; t++) begin
            do_op(t_mode[t], t_amt[t], t_x[t], t_poke[t], bc, got);
            chk($sformatf("dir%0d_done_seen", t), 32'(got), 32'h1);
            chk($sformatf("dir%0d_busy_cycles", t), 32'(bc), 32'(t_b[t]));
            chk($sformatf("dir%0d_f", t), 32'(f), 32'(t_f[t]));
            chk($sformatf("dir%0d_cout", t), 32'(cout), 32'(t_c[t]));
            chk($sformatf("dir%0d_ove", t), 32'(ove), 32'(t_o[t]));
            chk($sformatf("dir%0d_idle_after", t), 32'(busy), 32'h0);
        end

        // Reset in the middle of a long SLL aborts it without a done pulse.
        @(negedge clk);
        start = 1'b1; mode = 3'd1; amt = 3'd7; x = 8'hA5;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        chk("midrst_f",    32'(f),    32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        start = 1'b0;
        seen_done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        chk("midrst_no_done", 32'(seen_done), 32'h0);
        do_op(3'd1, 3'd2, 8'h03, 1'b0, bc, got);
        chk("postrst_done_seen", 32'(got), 32'h1);
        chk("postrst_f", 32'(f), 32'h0C);

        // Randomized traffic with occasional resets; checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 99) != 0);
            start = ($urandom_range(0, 2) == 0);
            mode  = 3'($urandom_range(0, 7));
            amt   = 3'($urandom_range(0, 7));
            x     = 8'($urandom);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
